// File: rtl/mdu_if.sv
// Handshake/data bundle between the EX-stage issue logic and the multiply/divide unit.
interface mdu_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, rs_val, rt_val, input busy, stall_req, hi, lo);
  modport slave  (input start, op, rs_val, rt_val, output busy, stall_req, hi, lo);
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed at issue
// and held back until the busy window expires, so hi/lo change only on commit.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave md
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   res_hi, res_lo, hi_q, lo_q;
  logic          res_ok;

  logic [31:0] rs, rt;
  assign rs = md.rs_val;
  assign rt = md.rt_val;

  logic [63:0] prod_s, prod_u;
  assign prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
  assign prod_u = {32'd0, rs} * {32'd0, rt};

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  logic        a_neg, b_neg;
  logic [31:0] ua, ub, sdv, udv, sq, sr, uq, ur;
  assign a_neg = rs[31];
  assign b_neg = rt[31];
  assign ua    = a_neg ? (~rs + 32'd1) : rs;
  assign ub    = b_neg ? (~rt + 32'd1) : rt;
  assign sdv   = (ub == 32'd0) ? 32'd1 : ub;
  assign udv   = (rt == 32'd0) ? 32'd1 : rt;
  assign sq    = ua / sdv;
  assign sr    = ua % sdv;
  assign uq    = rs / udv;
  assign ur    = rs % udv;

  logic [31:0] c_hi, c_lo;
  logic        c_ok;
  always_comb begin
    c_hi = 32'd0;
    c_lo = 32'd0;
    c_ok = 1'b1;
    case (md.op[1:0])
      2'd0: {c_hi, c_lo} = prod_s;
      2'd1: {c_hi, c_lo} = prod_u;
      2'd2: begin
        c_lo = (a_neg ^ b_neg) ? (~sq + 32'd1) : sq;
        c_hi = a_neg ? (~sr + 32'd1) : sr;
        c_ok = (rt != 32'd0);
      end
      default: begin
        c_lo = uq;
        c_hi = ur;
        c_ok = (rt != 32'd0);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      res_hi <= 32'd0;
      res_lo <= 32'd0;
      res_ok <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      case (state)
        IDLE: if (md.start) begin
          case (md.op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              res_hi <= c_hi;
              res_lo <= c_lo;
              res_ok <= c_ok;
              cnt    <= md.op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
              state  <= RUN;
            end
            3'd4:    hi_q <= rs;
            3'd5:    lo_q <= rs;
            default: ;
          endcase
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= IDLE;
            if (res_ok) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign md.busy      = (state == RUN);
  assign md.stall_req = md.busy | (md.start & ~md.op[2]);
  assign md.hi        = hi_q;
  assign md.lo        = lo_q;
endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multi-cycle multiply/divide unit in the EX stage. Owns the HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Its hi/lo outputs feed the MFHI/MFLO result path, which reaches the register file write port via the pipeline.
- Exposes busy/stall_req so the hazard unit can hold any MD-class instruction in ID while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy duration of MULT/MULTU in cycles (≥1)
- DIV_CYCLES, 10, busy duration of DIV/DIVU in cycles (≥1)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  valid MD instruction in EX this cycle
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved
- rs_val  input  32  forwarded rs operand (dividend / multiplicand / MT source)
- rt_val  input  32  forwarded rt operand (divisor / multiplier)
- busy  output  1  registered; high while a mult/div is in flight
- stall_req  output  1  combinational: busy | (start & op<=3)
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Clock and reset: clk, with reset synchronous and active-high.
- Reset:
  - Takes priority over everything else on the clk edge.
  - Sets busy=0 and clears hi, lo and the counter to 0.
  - Discards any pending result. A reset mid-operation cancels it; no late commit.
- States:
  - IDLE (busy=0) and RUN (busy=1).
  - A down-counter cnt of width clog2(max(MULT_CYCLES, DIV_CYCLES)) + 1 tracks the RUN duration.
- IDLE, start=1, op 0–3:
  - On edge T, latch the computed result into internal res_hi/res_lo.
  - Load cnt with MULT_CYCLES or DIV_CYCLES; set busy=1.
- RUN:
  - Each edge decrements cnt.
  - On the edge where cnt reaches 0, commit hi<=res_hi, lo<=res_lo and clear busy.
  - busy is therefore high for exactly N cycles (T+1..T+N), and the new hi/lo are visible from cycle T+N+1.
- hi/lo during RUN: hold their previous values until commit.
- MTHI/MTLO (op 4/5) in IDLE: hi<=rs_val or lo<=rs_val on the same edge. Never asserts busy.
- start while busy=1: ignored entirely, whatever the op. The hazard unit must not issue in this case.
- Reserved op (6/7): ignored.
- Back-to-back: a start in the first cycle with busy=0 is accepted. No dead cycle is required.
- Arithmetic:
  - MULT: {hi,lo} = signed 32×32 → 64.
  - MULTU: unsigned 32×32 → 64.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Boundary cases:
  - Divide by zero (rt_val=0, DIV/DIVU): full DIV_CYCLES busy period, but hi/lo keep their prior values at commit.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- Operand capture: operands are sampled only on the start edge. Later changes to rs_val/rt_val during RUN have no effect.
- stall_req: purely combinational. Asserted in the start cycle of a mult/div so the following instruction stalls.

Test Plan:
- Reset, then MULT rs=0xFFFFFFFE (−2), rt=0x00000003:
  - busy=1 for exactly 5 cycles.
  - hi=0xFFFFFFFF and lo=0xFFFFFFFA from cycle T+6.
  - hi/lo stay 0 until then.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
- DIV rs=0xFFFFFFF9 (−7), rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles.
- DIVU rs=7, rt=0, with prior hi=0x11, lo=0x22 → busy for 10 cycles; hi=0x11, lo=0x22 unchanged afterwards.
- Start and reset interaction:
  - MTLO rs=0x1234 → lo=0x1234 next cycle with busy=0.
  - MULT started, then MTHI start asserted at cycle T+2 → MTHI ignored; hi = MULT result at commit.
- Reset asserted at cycle T+3 of a DIV → busy=0 and hi=lo=0 next cycle. No commit appears at T+10.
